// File: rtl/rr_arb16.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb16
//  Purpose  : 16-way round-robin arbiter with a bounded hold time. A grant is
//             issued one cycle after a request is seen in IDLE. It is held until
//             the grantee pulses done, drops its request, or has held the grant
//             for MAX_HOLD cycles. Every release is followed by at least one
//             idle cycle. Priority then rotates to the requester after the one
//             just released.
//  Ports    : clk          - clock; all state changes on the rising edge
//             rst          - synchronous active-high reset
//             req[15:0]    - level-sensitive request, one bit per requester
//             done         - release strobe from the current grantee
//             grant_idx    - binary index of the current/last grantee
//             grant[15:0]  - one-hot decode of grant_idx while grant_valid=1
//             grant_valid  - a grant is being held
//             expired      - one-cycle pulse after a forced timeout release
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arb16 #(
   parameter int MAX_HOLD = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] req,
   input  logic        done,
   output logic [3:0]  grant_idx,
   output logic [15:0] grant,
   output logic        grant_valid,
   output logic        expired
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;

   localparam logic [3:0] c_max_hold = 4'(MAX_HOLD);

   if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_bad_max_hold
      $error("rr_arb16: MAX_HOLD must be in 1..15");
   end

   logic [0:0]  state_q,       state_d;
   logic [3:0]  ptr_q,         ptr_d;
   logic [3:0]  grant_idx_q,   grant_idx_d;
   logic [15:0] grant_q,       grant_d;
   logic        grant_valid_q, grant_valid_d;
   logic        expired_q,     expired_d;
   logic [3:0]  hold_q,        hold_d;

   logic [3:0]  w_pick;
   logic [3:0]  w_cand;
   logic        w_timeout;
   logic        w_req_drop;
   logic        w_release;

   // Circular search from ptr. The loop runs from the farthest candidate
   // down to ptr itself, so the last hit written is the closest one.
   always_comb begin
      w_pick = ptr_q;
      w_cand = ptr_q;
      for (int i = 15; i >= 0; i--) begin
         w_cand = ptr_q + 4'(i);
         if (req[w_cand]) begin
            w_pick = w_cand;
         end
      end
   end

   assign w_timeout  = (hold_q == c_max_hold);
   assign w_req_drop = ~req[grant_idx_q];
   assign w_release  = done | w_req_drop | w_timeout;

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      grant_idx_d   = grant_idx_q;
      grant_valid_d = grant_valid_q;
      hold_d        = hold_q;
      expired_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (|req) begin
               grant_idx_d   = w_pick;
               grant_valid_d = 1'b1;
               hold_d        = 4'd1;
               state_d       = GRANT;
            end
         end
         GRANT: begin
            if (w_release) begin
               grant_valid_d = 1'b0;
               ptr_d         = grant_idx_q + 4'd1;
               hold_d        = 4'd0;
               state_d       = IDLE;
               // Timeout is reported only when it is the sole cause; done or
               // a dropped request make the release a normal one.
               expired_d     = w_timeout & ~done & ~w_req_drop;
            end else begin
               hold_d        = hold_q + 4'd1;
            end
         end
         default: begin
            state_d       = IDLE;
            grant_valid_d = 1'b0;
         end
      endcase

      grant_d = grant_valid_d ? (16'h0001 << grant_idx_d) : 16'h0000;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         ptr_q         <= 4'd0;
         grant_idx_q   <= 4'd0;
         grant_q       <= 16'h0000;
         grant_valid_q <= 1'b0;
         expired_q     <= 1'b0;
         hold_q        <= 4'd0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         grant_idx_q   <= grant_idx_d;
         grant_q       <= grant_d;
         grant_valid_q <= grant_valid_d;
         expired_q     <= expired_d;
         hold_q        <= hold_d;
      end
   end

   assign grant_idx   = grant_idx_q;
   assign grant       = grant_q;
   assign grant_valid = grant_valid_q;
   assign expired     = expired_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_arb16.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rr_arb16
//  Purpose  : Self-checking bench for rr_arb16 (MAX_HOLD = 8): a vector table,
//             hand-written timeout and rotation sequences, and a random phase
//             compared every cycle against a behavioural arbiter model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arb16;

   localparam int MAX_HOLD = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] req;
   logic        done;
   logic [3:0]  grant_idx;
   logic [15:0] grant;
   logic        grant_valid;
   logic        expired;

   int n_checks = 0;
   int n_fail   = 0;

   rr_arb16 #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .done        (done),
      .grant_idx   (grant_idx),
      .grant       (grant),
      .grant_valid (grant_valid),
      .expired     (expired)
   );

   always #5 clk = ~clk;

   // Behavioural model: who owns the bus, for how long, and where the
   // rotation continues from.
   bit m_busy;
   int m_owner;
   int m_held;
   int m_ptr;
   bit m_exp;

   function automatic int first_from(int p, logic [15:0] r);
      for (int k = 0; k < 16; k++) begin
         if (r[(p + k) % 16]) return (p + k) % 16;
      end
      return p;
   endfunction

   task automatic model_edge(input logic r_rst, input logic [15:0] r_req, input logic r_done);
      if (r_rst) begin
         m_busy = 0; m_owner = 0; m_held = 0; m_ptr = 0; m_exp = 0;
      end else if (!m_busy) begin
         m_exp = 0;
         if (r_req != 16'h0) begin
            m_owner = first_from(m_ptr, r_req);
            m_busy  = 1;
            m_held  = 1;
         end
      end else if (r_done || !r_req[m_owner]) begin
         m_busy = 0; m_exp = 0; m_ptr = (m_owner + 1) % 16;
      end else if (m_held >= MAX_HOLD) begin
         m_busy = 0; m_exp = 1; m_ptr = (m_owner + 1) % 16;
      end else begin
         m_held = m_held + 1;
         m_exp  = 0;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive inputs, clock one edge, update model, then compare away from the edge.
   task automatic apply(input logic a_rst, input logic [15:0] a_req, input logic a_done);
      logic [15:0] m_grant;
      rst = a_rst; req = a_req; done = a_done;
      @(posedge clk);
      model_edge(a_rst, a_req, a_done);
      #1;
      m_grant = m_busy ? (16'h0001 << m_owner) : 16'h0000;
      chk("model_valid",   32'(grant_valid), 32'(m_busy));
      chk("model_idx",     32'(grant_idx),   32'(m_owner));
      chk("model_grant",   32'(grant),       32'(m_grant));
      chk("model_expired", 32'(expired),     32'(m_exp));
   endtask

   task automatic expect_out(input string name, input logic v, input logic [3:0] idx, input logic e);
      logic [15:0] g;
      g = v ? (16'h0001 << idx) : 16'h0000;
      chk({name, "_valid"},   32'(grant_valid), 32'(v));
      chk({name, "_idx"},     32'(grant_idx),   32'(idx));
      chk({name, "_grant"},   32'(grant),       32'(g));
      chk({name, "_expired"}, 32'(expired),     32'(e));
   endtask

   typedef struct {
      logic        rst;
      logic [15:0] req;
      logic        done;
      logic        v;
      logic [3:0]  idx;
      logic        e;
   } vec_t;

   vec_t tbl [20];

   initial begin
      logic [15:0] rq;
      rst = 1'b1; req = 16'h0; done = 1'b0;

      // Outputs expected after the edge on which the row's inputs are sampled.
      tbl[0]  = '{1'b1, 16'h0000, 1'b0, 1'b0, 4'd0,  1'b0};
      tbl[1]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 4'd0,  1'b0};
      tbl[2]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 4'd0,  1'b0};
      tbl[3]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 4'd0,  1'b0};
      tbl[4]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 4'd0,  1'b0};
      tbl[5]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 4'd0,  1'b0};
      tbl[6]  = '{1'b0, 16'h0001, 1'b0, 1'b1, 4'd0,  1'b0};
      tbl[7]  = '{1'b0, 16'h0001, 1'b0, 1'b1, 4'd0,  1'b0};
      tbl[8]  = '{1'b0, 16'h0001, 1'b0, 1'b1, 4'd0,  1'b0};
      tbl[9]  = '{1'b0, 16'h0001, 1'b1, 1'b0, 4'd0,  1'b0};
      tbl[10] = '{1'b0, 16'h8001, 1'b0, 1'b1, 4'd15, 1'b0};
      tbl[11] = '{1'b0, 16'h8001, 1'b1, 1'b0, 4'd15, 1'b0};
      tbl[12] = '{1'b0, 16'h8001, 1'b0, 1'b1, 4'd0,  1'b0};
      tbl[13] = '{1'b0, 16'h8001, 1'b1, 1'b0, 4'd0,  1'b0};
      tbl[14] = '{1'b0, 16'h0020, 1'b0, 1'b1, 4'd5,  1'b0};
      tbl[15] = '{1'b1, 16'h0020, 1'b0, 1'b0, 4'd0,  1'b0};
      tbl[16] = '{1'b0, 16'hFFFF, 1'b0, 1'b1, 4'd0,  1'b0};
      tbl[17] = '{1'b0, 16'hFFFF, 1'b1, 1'b0, 4'd0,  1'b0};
      tbl[18] = '{1'b0, 16'h0004, 1'b0, 1'b1, 4'd2,  1'b0};
      tbl[19] = '{1'b0, 16'h0000, 1'b0, 1'b0, 4'd2,  1'b0};

      for (int i = 0; i < 20; i++) begin
         apply(tbl[i].rst, tbl[i].req, tbl[i].done);
         expect_out($sformatf("vec%0d", i), tbl[i].v, tbl[i].idx, tbl[i].e);
      end

      // Timeout: idx 4 holds for exactly MAX_HOLD cycles, expires, then idx 5.
      apply(1'b1, 16'h0000, 1'b0);
      for (int c = 0; c < MAX_HOLD; c++) begin
         apply(1'b0, 16'h0030, 1'b0);
         expect_out("hold4", 1'b1, 4'd4, 1'b0);
      end
      apply(1'b0, 16'h0030, 1'b0);
      expect_out("expire4", 1'b0, 4'd4, 1'b1);
      apply(1'b0, 16'h0030, 1'b0);
      expect_out("next5", 1'b1, 4'd5, 1'b0);
      // done coinciding with the timeout is a normal release.
      for (int c = 1; c < MAX_HOLD; c++) apply(1'b0, 16'h0030, 1'b0);
      expect_out("hold5_last", 1'b1, 4'd5, 1'b0);
      apply(1'b0, 16'h0030, 1'b1);
      expect_out("done_vs_timeout", 1'b0, 4'd5, 1'b0);

      // Full rotation with every requester asking and done held high.
      apply(1'b1, 16'h0000, 1'b0);
      for (int k = 0; k <= 16; k++) begin
         apply(1'b0, 16'hFFFF, 1'b1);
         expect_out($sformatf("rot%0d", k), 1'b1, 4'(k % 16), 1'b0);
         apply(1'b0, 16'hFFFF, 1'b1);
         expect_out($sformatf("bubble%0d", k), 1'b0, 4'(k % 16), 1'b0);
      end

      // Random phase against the model.
      rq = 16'h0;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 9) < 3) begin
            rq = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom & $urandom);
         end
         apply($urandom_range(0, 99) == 0, rq, $urandom_range(0, 3) == 0);
         chk("onehot", 32'($countones(grant) <= 1), 32'd1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/rr_arb16.md
RR_ARB16 -- requirements
Module: rr_arb16

Interface
REQ-001 SHALL provide parameter MAX_HOLD, default 8, giving the maximum consecutive cycles one grant is held; legal range 1..15.
REQ-002 SHALL provide port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL provide port rst, input, 1, reset; it is synchronous and active-high.
REQ-004 SHALL provide port req, input, 16, one request bit per requester, level-sensitive.
REQ-005 SHALL provide port done, input, 1, release strobe from the current grantee, sampled only while grant_valid=1.
REQ-006 SHALL provide port grant_idx, output, 4, binary index of the current grantee, the select code for the shared 4-to-16 decode.
REQ-007 SHALL provide port grant, output, 16, one-hot grant equal to the 4-to-16 decode of grant_idx when grant_valid=1, else all zero.
REQ-008 SHALL provide port grant_valid, output, 1, high while a grant is held.
REQ-009 SHALL provide port expired, output, 1, single-cycle pulse marking a forced release by hold timeout.

Function
REQ-010 SHALL implement a two-state FSM: IDLE, GRANT; all outputs registered.
REQ-011 SHALL keep a 4-bit priority pointer ptr; the highest priority is ptr, then ptr+1, ..., wrapping 15->0.
REQ-012 In IDLE with req!=0 at an edge, SHALL select the first set req bit searching circularly from ptr, load grant_idx, set grant_valid=1, load hold count=1, and enter GRANT.
REQ-013 In IDLE with req=0, SHALL remain in IDLE with grant=0 and grant_valid=0; grant_idx holds its last value.
REQ-014 Latency SHALL be one cycle: req sampled at edge N gives grant visible after edge N.
REQ-015 In GRANT, SHALL release at an edge when done=1, when req[grant_idx]=0, or when hold count==MAX_HOLD.
REQ-016 On release, SHALL clear grant_valid and grant, set ptr=grant_idx+1 mod 16, and return to IDLE.
REQ-017 Each release SHALL produce at least one IDLE cycle before the next grant (one-cycle bubble).
REQ-018 Without a release, SHALL increment the hold count each cycle and keep grant_idx stable.
REQ-019 expired SHALL pulse for exactly one cycle, coincident with the first IDLE cycle, only when the release cause was the timeout.
REQ-020 If done=1 and the timeout coincide, SHALL treat the release as done and keep expired=0.
REQ-021 A grantee dropping its req SHALL count as a normal release with expired=0.
REQ-022 Requests from non-grantees SHALL never preempt an active grant.
REQ-023 grant SHALL never have more than one bit set.
REQ-024 A grantee SHALL hold grant for at most MAX_HOLD consecutive cycles.

Reset
REQ-025 When rst=1 at an edge, SHALL set state=IDLE, ptr=0, grant_idx=0, grant=0, grant_valid=0, expired=0, and hold count=0, regardless of req or done.
REQ-026 Reset asserted mid-grant SHALL drop grant at that edge with no expired pulse.
REQ-027 Reset SHALL take precedence over all other events.
REQ-028 After reset deassertion, arbitration SHALL restart from ptr=0.

Verification
REQ-029 Reset, req=16'h0000 for 5 cycles -> grant=0, grant_valid=0, expired=0 throughout.
REQ-030 After reset, req=16'h0001, done pulsed 3 cycles later -> grant=16'h0001 and grant_idx=0 one cycle after req; release follows done; ptr=1.
REQ-031 With ptr=1, req=16'h8001 -> grant=16'h8000 (idx 15); after done, bubble, ptr wraps to 0 -> grant=16'h0001.
REQ-032 MAX_HOLD=8, req=16'h0030 held, done=0 -> grant=16'h0010 for exactly 8 cycles, expired pulse, bubble, then grant=16'h0020.
REQ-033 req=16'hFFFF constant, done=1 every grant cycle -> grant_idx sequence 0,1,...,15,0, with one idle cycle between grants.
REQ-034 Grant on idx 5, rst=1 for one cycle -> next cycle grant=0 and grant_valid=0; with req=16'hFFFF, the next grant is idx 0.
